// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, LOAD, CHK, DONE, ERR} state_t;

    localparam int HDR_BYTES = 2;

    function automatic int bytes_per_word(input int inst_w);
        return inst_w / 8;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian words; word_o is the completed word while word_done is high.
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [7:0]        data_i,
    output logic [INST_W-1:0] word_o,
    output logic              word_done
);

    localparam int BPW = bytes_per_word(INST_W);
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [INST_W-1:0] sr;
    logic [IW-1:0]     idx;

    // Newest byte enters at the top, so the first byte ends up least significant.
    generate
        if (INST_W == 8) begin : g_single
            assign word_o = data_i;
        end else begin : g_multi
            assign word_o = {data_i, sr[INST_W-1:8]};
        end
    endgenerate

    assign word_done = en && (idx == IW'(BPW - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr  <= '0;
            idx <= '0;
        end else if (clr) begin
            sr  <= '0;
            idx <= '0;
        end else if (en) begin
            sr  <= word_o;
            idx <= word_done ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory, then releases the core.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [INST_W-1:0] mem_wdata_o,
    output logic              core_run_o,
    output logic              done_o,
    output logic              err_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t FIN = CHK;
`else
    localparam state_t FIN = DONE;
`endif

    state_t            state, state_nx;
    logic [7:0]        n_lo;
    logic [15:0]       n_words, wcnt, hdr_n;
    logic [ADDR_W:0]   addr;
    logic              xfer, word_done, last_word;
    logic [INST_W-1:0] word;

    assign rx_ready_o = (state == HDR0) || (state == HDR1) || (state == LOAD) || (state == CHK);
    assign xfer       = rx_valid_i && rx_ready_o;
    assign hdr_n      = {rx_data_i, n_lo};
    assign last_word  = (17'(wcnt) + 17'd1) == 17'(n_words);
    assign core_run_o = (state == DONE);
    assign done_o     = (state == DONE);
    assign err_o      = (state == ERR);

    byte_packer #(.INST_W(INST_W)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == HDR0),
        .en        (xfer && (state == LOAD)),
        .data_i    (rx_data_i),
        .word_o    (word),
        .word_done (word_done)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        csum <= '0;
        else if (state == HDR0)          csum <= '0;
        else if (state == LOAD && xfer)  csum <= csum ^ rx_data_i;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = HDR0;
            HDR0: if (xfer) state_nx = HDR1;
            HDR1: if (xfer) begin
                if (hdr_n == 16'd0)                         state_nx = FIN;
                else if (32'(hdr_n) > (32'd1 << ADDR_W))    state_nx = ERR;
                else                                        state_nx = LOAD;
            end
            LOAD: begin
                // The overflow arm is defensive; the header check already bounds N.
                if (word_done && addr[ADDR_W])    state_nx = ERR;
                else if (word_done && last_word)  state_nx = FIN;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:  if (xfer) state_nx = (rx_data_i == csum) ? DONE : ERR;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_lo        <= '0;
            n_words     <= '0;
            wcnt        <= '0;
            addr        <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_we_o <= 1'b0;
            if (state == HDR0) begin
                wcnt <= '0;
                addr <= '0;
                if (xfer) n_lo <= rx_data_i;
            end
            if (state == HDR1 && xfer) n_words <= hdr_n;
            // Address and data hold between writes; only the enable is a pulse.
            if (word_done) begin
                mem_we_o    <= 1'b1;
                mem_addr_o  <= addr[ADDR_W-1:0];
                mem_wdata_o <= word;
                addr        <= addr + 1'b1;
                wcnt        <= wcnt + 16'd1;
            end
        end
    end

endmodule
